// File: rtl/cond_unit_banked.sv
// Registered ARM condition unit with per-context NZCV flag banks and an
// IT-style predication sequencer that overrides the next 1..ITMAX conditions.
module cond_unit_banked #(
    parameter  int NBANK = 2,
    parameter  int ITMAX = 4,
    localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1,
    localparam int LW    = $clog2(ITMAX + 1),
    localparam int SW    = (ITMAX > 1) ? $clog2(ITMAX) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BW-1:0]    Bank,
    input  logic             Eval,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NextPC,
    input  logic             ItStart,
    input  logic [3:0]       ItCond,
    input  logic [LW-1:0]    ItLen,
    input  logic [ITMAX-1:0] ItMask,
    output logic             CondEx,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             ItActive,
    output logic [LW-1:0]    ItRemain
);

    logic [3:0]       banks [NBANK];
    logic [3:0]       flags_cur;
    logic [3:0]       eff_cond;
    logic             inv_bit;
    logic             len_ok;
    logic             it_active;
    logic [LW-1:0]    it_remain;
    logic [SW-1:0]    slot;
    logic [3:0]       it_cond;
    logic [ITMAX-1:0] it_mask;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, ge;
        {n, z, cf, v} = f;
        ge = (n == v);
        case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = cf;
            4'b0011: cond_eval = ~cf;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = cf & ~z;
            4'b1001: cond_eval = ~cf | z;
            4'b1010: cond_eval = ge;
            4'b1011: cond_eval = ~ge;
            4'b1100: cond_eval = ~z & ge;
            4'b1101: cond_eval = z | ~ge;
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        flags_cur = 4'b0000;
        for (int b = 0; b < NBANK; b++) begin
            if (Bank == BW'(b)) flags_cur = banks[b];
        end
    end

    // Slot index can run past ITMAX-1 once the block drains; the loop keeps it in range.
    always_comb begin
        inv_bit = 1'b0;
        for (int s = 0; s < ITMAX; s++) begin
            if (slot == SW'(s)) inv_bit = it_mask[s];
        end
    end

    always_comb begin
        eff_cond = Cond;
        if (it_active) begin
            if (it_cond[3:1] == 3'b111) eff_cond = it_cond;
            else                        eff_cond = {it_cond[3:1], it_cond[0] ^ inv_bit};
        end
    end

    assign len_ok = (ItLen != '0) && (ItLen <= LW'(ITMAX));

    // NOTE: the flag banks are architectural state and must come up cleared, so
    // the array is reset like any other register; state updates are non-blocking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NBANK; b++) banks[b] <= 4'b0000;
            CondEx    <= 1'b0;
            it_active <= 1'b0;
            it_remain <= '0;
            slot      <= '0;
            it_cond   <= 4'b0000;
            it_mask   <= '0;
        end else begin
            if (Eval) CondEx <= cond_eval(eff_cond, flags_cur);

            // Write-back is gated by the CondEx latched before this edge.
            for (int b = 0; b < NBANK; b++) begin
                if (Bank == BW'(b)) begin
                    if (FlagW[1] && CondEx) banks[b][3:2] <= ALUFlags[3:2];
                    if (FlagW[0] && CondEx) banks[b][1:0] <= ALUFlags[1:0];
                end
            end

            if (Eval && it_active) begin
                it_remain <= it_remain - LW'(1);
                slot      <= slot + SW'(1);
                if (it_remain == LW'(1)) it_active <= 1'b0;
            end

            // A new block wins over the slot consumed by a coincident Eval.
            if (ItStart && len_ok) begin
                it_remain <= ItLen;
                slot      <= '0;
                it_active <= 1'b1;
                it_cond   <= ItCond;
                it_mask   <= ItMask;
            end
        end
    end

    assign PCWrite  = (PCS & CondEx) | NextPC;
    assign RegWrite = RegW & CondEx;
    assign MemWrite = MemW & CondEx;
    assign Flags    = flags_cur;
    assign ItActive = it_active;
    assign ItRemain = it_remain;

endmodule

// File: tb/tb_cond_unit_banked.sv
// Scoreboard bench for cond_unit_banked (4 banks, ITMAX=4): stimulus pushes
// expected output values, a negedge monitor pops and compares them.
module tb_cond_unit_banked;

    localparam int NBANK = 4;
    localparam int ITMAX = 4;
    localparam int BW    = 2;
    localparam int LW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [BW-1:0]    Bank;
    logic             Eval;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW, NextPC;
    logic             ItStart;
    logic [3:0]       ItCond;
    logic [LW-1:0]    ItLen;
    logic [ITMAX-1:0] ItMask;
    logic             CondEx, PCWrite, RegWrite, MemWrite;
    logic [3:0]       Flags;
    logic             ItActive;
    logic [LW-1:0]    ItRemain;

    cond_unit_banked #(.NBANK(NBANK), .ITMAX(ITMAX)) dut (
        .clk(clk), .reset(reset), .Bank(Bank), .Eval(Eval), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NextPC(NextPC), .ItStart(ItStart), .ItCond(ItCond), .ItLen(ItLen),
        .ItMask(ItMask), .CondEx(CondEx), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Flags(Flags), .ItActive(ItActive), .ItRemain(ItRemain)
    );

    always #5 clk = ~clk;

    typedef enum {S_CONDEX, S_PCW, S_REGW, S_MEMW, S_FLAGS, S_ITACT, S_ITREM} sig_e;
    typedef struct {
        sig_e       sig;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [3:0] pick(input sig_e s);
        case (s)
            S_CONDEX: pick = {3'b000, CondEx};
            S_PCW:    pick = {3'b000, PCWrite};
            S_REGW:   pick = {3'b000, RegWrite};
            S_MEMW:   pick = {3'b000, MemWrite};
            S_FLAGS:  pick = Flags;
            S_ITACT:  pick = {3'b000, ItActive};
            default:  pick = {1'b0, ItRemain};
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, pick(e.sig), e.val);
        end
    end

    task automatic expect_sig(input sig_e s, input logic [3:0] v, input string name);
        exp_t e;
        e.sig  = s;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        Eval    = 1'b0;
        ItStart = 1'b0;
        FlagW   = 2'b00;
        NextPC  = 1'b0;
    endtask

    // Evaluate all 16 codes on one bank; each result is checked a cycle later.
    task automatic sweep(input logic [BW-1:0] b, input logic [15:0] tbl);
        for (int i = 0; i <= 16; i++) begin
            clr();
            Bank = b;
            if (i < 16) begin
                Eval = 1'b1;
                Cond = 4'(i);
            end
            if (i > 0) expect_sig(S_CONDEX, {3'b000, tbl[i-1]}, $sformatf("cond%0d_bank%0d", i - 1, b));
            step();
        end
    endtask

    logic [15:0] tbl_b3;
    logic [15:0] tbl_b0;

    initial begin
        // Flags 0010 (C only) and 1100 (N,Z): bit i is the result of condition i.
        tbl_b3 = 16'h55A6;
        tbl_b0 = 16'h6A99;

        reset = 1'b0; Bank = '0; Cond = 4'h0; ALUFlags = 4'h0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
        ItCond = 4'h0; ItLen = '0; ItMask = '0;
        clr();
        step(); step();

        reset = 1'b1; clr(); Bank = 2'd0; Eval = 1'b1; Cond = 4'hE; step();
        clr(); Bank = 2'd1; FlagW = 2'b11; ALUFlags = 4'b1010;
        expect_sig(S_CONDEX, 4'd1, "al_condex"); step();
        clr(); PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        ItStart = 1'b1; ItCond = 4'h0; ItLen = 3'd2; ItMask = 4'b0000;
        expect_sig(S_FLAGS, 4'b1010, "bank1_before_reset");
        expect_sig(S_REGW, 4'd1, "regw_before_reset");
        expect_sig(S_PCW, 4'd1, "pcw_before_reset");
        step();

        // Asynchronous reset asserted mid-cycle, checked before the next edge.
        clr(); reset = 1'b0;
        expect_sig(S_CONDEX, 4'd0, "rst_condex");
        expect_sig(S_PCW, 4'd0, "rst_pcwrite");
        expect_sig(S_REGW, 4'd0, "rst_regwrite");
        expect_sig(S_MEMW, 4'd0, "rst_memwrite");
        expect_sig(S_FLAGS, 4'd0, "rst_flags");
        expect_sig(S_ITACT, 4'd0, "rst_itactive");
        expect_sig(S_ITREM, 4'd0, "rst_itremain");
        step();

        clr(); reset = 1'b1; PCS = 1'b1; RegW = 1'b0; MemW = 1'b0;
        expect_sig(S_FLAGS, 4'b0000, "bank1_cleared");
        expect_sig(S_PCW, 4'd0, "pcw_no_nextpc");
        step();
        clr(); NextPC = 1'b1; PCS = 1'b0; Bank = 2'd0; Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_PCW, 4'd1, "pcw_nextpc"); step();
        clr(); FlagW = 2'b10; ALUFlags = 4'b0100;
        expect_sig(S_CONDEX, 4'd1, "reset_aborts_block"); step();

        clr(); Eval = 1'b1; Cond = 4'h0;
        expect_sig(S_FLAGS, 4'b0100, "bank0_z_set"); step();
        clr(); RegW = 1'b1; MemW = 1'b1; Eval = 1'b1; Cond = 4'h1;
        expect_sig(S_CONDEX, 4'd1, "eq_true");
        expect_sig(S_REGW, 4'd1, "regwrite_on");
        expect_sig(S_MEMW, 4'd1, "memwrite_on");
        step();
        clr(); Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_CONDEX, 4'd0, "ne_false");
        expect_sig(S_REGW, 4'd0, "regwrite_off");
        expect_sig(S_MEMW, 4'd0, "memwrite_off");
        step();
        clr(); Eval = 1'b1; Cond = 4'hF;
        expect_sig(S_CONDEX, 4'd1, "al_true"); step();
        clr(); RegW = 1'b0; MemW = 1'b0; Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_CONDEX, 4'd0, "nv_false"); step();

        clr(); FlagW = 2'b10; ALUFlags = 4'hF;
        expect_sig(S_CONDEX, 4'd1, "condex_for_nz"); step();
        clr(); Eval = 1'b1; Cond = 4'hF;
        expect_sig(S_FLAGS, 4'b1100, "nz_write_cv_kept"); step();
        clr(); FlagW = 2'b01; ALUFlags = 4'hF;
        expect_sig(S_CONDEX, 4'd0, "condex_for_gate"); step();
        clr(); Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_FLAGS, 4'b1100, "cv_write_gated"); step();
        clr(); Bank = 2'd1; FlagW = 2'b01; ALUFlags = 4'hF;
        expect_sig(S_CONDEX, 4'd1, "condex_for_bank1"); step();
        clr(); Bank = 2'd0;
        expect_sig(S_FLAGS, 4'b1100, "bank0_isolated"); step();

        // Same-cycle Eval and write-back: eval sees old flags, write uses old CondEx.
        clr(); Bank = 2'd1; Eval = 1'b1; Cond = 4'h0; FlagW = 2'b10; ALUFlags = 4'b0100;
        expect_sig(S_FLAGS, 4'b0011, "bank1_cv_written"); step();
        clr(); Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_CONDEX, 4'd0, "eval_reads_old_flags");
        expect_sig(S_FLAGS, 4'b0111, "write_uses_old_condex");
        step();

        clr(); Bank = 2'd2; FlagW = 2'b11; ALUFlags = 4'b0100;
        expect_sig(S_CONDEX, 4'd1, "condex_for_bank2"); step();
        clr();
        expect_sig(S_FLAGS, 4'b0100, "bank2_flags"); step();
        clr(); Bank = 2'd3; Eval = 1'b1; Cond = 4'h0;
        expect_sig(S_FLAGS, 4'b0000, "bank3_flags"); step();

        clr(); Bank = 2'd0; ItStart = 1'b1; ItCond = 4'h0; ItLen = 3'd3; ItMask = 4'b0010;
        expect_sig(S_CONDEX, 4'd0, "bank3_eq_false"); step();
        clr(); Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_ITACT, 4'd1, "it_start_active");
        expect_sig(S_ITREM, 4'd3, "it_start_remain");
        step();
        clr(); Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_CONDEX, 4'd1, "it_slot0_eq");
        expect_sig(S_ITREM, 4'd2, "it_remain_2");
        expect_sig(S_ITACT, 4'd1, "it_active_2");
        step();
        clr(); Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_CONDEX, 4'd0, "it_slot1_ne");
        expect_sig(S_ITREM, 4'd1, "it_remain_1");
        step();
        clr(); Eval = 1'b1; Cond = 4'h1;
        expect_sig(S_CONDEX, 4'd1, "it_slot2_eq");
        expect_sig(S_ITREM, 4'd0, "it_remain_0");
        expect_sig(S_ITACT, 4'd0, "it_done");
        step();
        clr(); ItStart = 1'b1; ItLen = 3'd0;
        expect_sig(S_CONDEX, 4'd0, "after_block_uses_cond"); step();
        clr(); ItStart = 1'b1; ItLen = 3'd1; ItCond = 4'hE; ItMask = 4'b0000;
        expect_sig(S_ITACT, 4'd0, "len0_ignored_active");
        expect_sig(S_ITREM, 4'd0, "len0_ignored_remain");
        step();
        clr(); ItStart = 1'b1; ItLen = 3'd5;
        expect_sig(S_ITACT, 4'd1, "len1_active");
        expect_sig(S_ITREM, 4'd1, "len1_remain");
        step();

        // Restart coinciding with the Eval that drains the last slot.
        clr(); Eval = 1'b1; Cond = 4'h1; ItStart = 1'b1; ItLen = 3'd2; ItCond = 4'h1; ItMask = 4'b0001;
        expect_sig(S_ITREM, 4'd1, "len5_ignored"); step();
        clr(); Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_CONDEX, 4'd1, "last_slot_eval");
        expect_sig(S_ITREM, 4'd2, "restart_remain");
        expect_sig(S_ITACT, 4'd1, "restart_active");
        step();
        clr(); Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_CONDEX, 4'd1, "new_slot0_inverted");
        expect_sig(S_ITREM, 4'd1, "new_remain_1");
        step();
        clr(); Eval = 1'b1; Cond = 4'hE; ItStart = 1'b1; ItLen = 3'd1; ItCond = 4'hF; ItMask = 4'b0001;
        expect_sig(S_CONDEX, 4'd0, "new_slot1_plain");
        expect_sig(S_ITACT, 4'd0, "new_block_done");
        step();
        clr(); Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_CONDEX, 4'd1, "idle_eval_al");
        expect_sig(S_ITACT, 4'd1, "nv_block_active");
        step();
        clr(); Eval = 1'b1; Cond = 4'hE;
        expect_sig(S_CONDEX, 4'd0, "nv_invert_ignored");
        expect_sig(S_ITACT, 4'd0, "nv_block_done");
        step();

        clr(); Bank = 2'd3; FlagW = 2'b11; ALUFlags = 4'b0010;
        expect_sig(S_CONDEX, 4'd1, "condex_for_bank3"); step();
        clr();
        expect_sig(S_FLAGS, 4'b0010, "bank3_c_only"); step();
        sweep(2'd3, tbl_b3);
        sweep(2'd0, tbl_b0);

        clr(); step();
        @(negedge clk); #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
